// File: rtl/hazard_ctrl_md_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_md_pkg
// Shared definitions for the MIPS hazard controller with a multiply/divide
// busy tracker: opcode and funct constants, Tuse/Tnew encodings, default
// MULT/DIV latencies and the per-stage decode record.
// Optional feature: HAZARD_PERF_EN (stall counter in the top level).
// ---------------------------------------------------------------------------
package hazard_ctrl_md_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  // Tuse: cycles until D needs the operand (3 = never used)
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles until a producer's result can be forwarded
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // Default multiply/divide latencies after the op leaves E
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Class flags for one decoded instruction
  typedef struct packed {
    logic calcR;       // register-register ALU op, shifts included
    logic constShift;  // sll/srl/sra: rs field is not read
    logic calcI;       // immediate ALU op, lui included
    logic load;
    logic store;
    logic branch;
    logic jumpReg;     // jr/jalr
    logic jal;
    logic mdMult;      // mult/multu
    logic mdDiv;       // div/divu
    logic mfHiLo;      // mfhi/mflo
    logic mtHiLo;      // mthi/mtlo
  } instr_class_t;

  // True for anything that occupies or reads the HI/LO unit
  function automatic logic isMdClass(input instr_class_t cls);
    return cls.mdMult | cls.mdDiv | cls.mfHiLo | cls.mtHiLo;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// ---------------------------------------------------------------------------
// hazard_decode
// Decodes one raw instruction word into class flags, source registers and
// the destination register (0 when nothing is written). Instantiated once
// per pipeline stage (D, E, M) by hazard_ctrl_md.
// Ports:
//   instr_i  in  32  raw instruction word (0 is a bubble)
//   cls_o    out     class flags (instr_class_t)
//   rs_o     out  5  rs field
//   rt_o     out  5  rt field
//   dest_o   out  5  destination register (rd, rt, 31 or 0)
// Configuration macro HAZARD_PERF_EN has no effect on this module.
// ---------------------------------------------------------------------------
module hazard_decode
  import hazard_ctrl_md_pkg::*;
(
  input  logic [31:0]  instr_i,
  output instr_class_t cls_o,
  output logic [4:0]   rs_o,
  output logic [4:0]   rt_o,
  output logic [4:0]   dest_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rdField;
  logic       unusedShamt;

  assign opcode      = instr_i[31:26];
  assign funct       = instr_i[5:0];
  assign rdField     = instr_i[15:11];
  assign unusedShamt = ^instr_i[10:6];

  assign rs_o = instr_i[25:21];
  assign rt_o = instr_i[20:16];

  // Classify the word and pick its destination. A bubble (all zero) decodes
  // as sll $0,$0,0 which writes register 0, so it can never cause a hazard.
  always_comb begin
    cls_o  = '0;
    dest_o = 5'd0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA: begin
            cls_o.calcR      = 1'b1;
            cls_o.constShift = 1'b1;
            dest_o           = rdField;
          end
          FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            cls_o.calcR = 1'b1;
            dest_o      = rdField;
          end
          FN_JR: cls_o.jumpReg = 1'b1;
          FN_JALR: begin
            cls_o.jumpReg = 1'b1;
            dest_o        = rdField;
          end
          FN_MULT, FN_MULTU: cls_o.mdMult = 1'b1;
          FN_DIV, FN_DIVU:   cls_o.mdDiv  = 1'b1;
          FN_MFHI, FN_MFLO: begin
            cls_o.mfHiLo = 1'b1;
            dest_o       = rdField;
          end
          FN_MTHI, FN_MTLO: cls_o.mtHiLo = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LUI: begin
        cls_o.calcI = 1'b1;
        dest_o      = rt_o;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        cls_o.load = 1'b1;
        dest_o     = rt_o;
      end
      OP_SB, OP_SH, OP_SW: cls_o.store = 1'b1;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls_o.branch = 1'b1;
      OP_JAL: begin
        cls_o.jal = 1'b1;
        dest_o    = 5'd31;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl_md.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_md
// Stall controller for a 5-stage MIPS pipeline: Tuse/Tnew data-hazard
// detection between D and E/M, plus a busy counter for the multi-cycle
// multiply/divide unit.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   D_Instr/E_Instr/M_Instr  in 32  instruction words per stage (0 = bubble)
//   Stall                 out  freeze PC and F/D, bubble into D/E
//   PC_WrEn, FD_REG_WrEn  out  !Stall
//   DE_REG_Flush          out  Stall
//   MD_Busy               out  multiply/divide unit occupied
//   MD_Start              out  E holds mult/multu/div/divu
//   Stall_Cnt             out 32  saturating stall-cycle count
//                              (only when HAZARD_PERF_EN is defined)
// ---------------------------------------------------------------------------
module hazard_ctrl_md
  import hazard_ctrl_md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D_Instr,
  input  logic [31:0] E_Instr,
  input  logic [31:0] M_Instr,
  output logic        Stall,
  output logic        PC_WrEn,
  output logic        FD_REG_WrEn,
  output logic        DE_REG_Flush,
  output logic        MD_Busy,
  output logic        MD_Start
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] Stall_Cnt
`endif
);

  instr_class_t dCls, eCls, mCls;
  logic [4:0]   dRs, dRt, dDest;
  logic [4:0]   eRs, eRt, eDest;
  logic [4:0]   mRs, mRt, mDest;

  logic [1:0]   dTuseRs, dTuseRt;
  logic [1:0]   eTnew, mTnew;
  logic         dataStall, mdStall;

  logic [CNT_W-1:0] busyCnt_q, busyCnt_d;

  logic         unusedDecode;

  hazard_decode u_decD (.instr_i(D_Instr), .cls_o(dCls), .rs_o(dRs), .rt_o(dRt), .dest_o(dDest));
  hazard_decode u_decE (.instr_i(E_Instr), .cls_o(eCls), .rs_o(eRs), .rt_o(eRt), .dest_o(eDest));
  hazard_decode u_decM (.instr_i(M_Instr), .cls_o(mCls), .rs_o(mRs), .rt_o(mRt), .dest_o(mDest));

  // Only some decode fields matter per stage; fold the rest into one sink.
  assign unusedDecode = ^{dDest, eRs, eRt, mRs, mRt, mCls, eCls.constShift,
                          eCls.store, eCls.branch, eCls.jumpReg, eCls.jal,
                          eCls.mtHiLo};

  // When D needs each source: branches and register jumps compare in D,
  // ALU-style consumers in E, and store data only in M.
  always_comb begin
    dTuseRs = TUSE_NONE;
    dTuseRt = TUSE_NONE;
    if (dCls.branch || dCls.jumpReg)
      dTuseRs = TUSE_0;
    else if ((dCls.calcR && !dCls.constShift) || dCls.calcI || dCls.load ||
             dCls.store || dCls.mdMult || dCls.mdDiv || dCls.mtHiLo)
      dTuseRs = TUSE_1;

    if (dCls.branch)
      dTuseRt = TUSE_0;
    else if (dCls.calcR || dCls.mdMult || dCls.mdDiv)
      dTuseRt = TUSE_1;
    else if (dCls.store)
      dTuseRt = TUSE_2;
  end

  // When the producer in E or M can forward its result.
  always_comb begin
    eTnew = TNEW_0;
    if (eCls.load)
      eTnew = TNEW_2;
    else if (eCls.calcR || eCls.calcI || eCls.mfHiLo)
      eTnew = TNEW_1;
    mTnew = mCls.load ? TNEW_1 : TNEW_0;
  end

  // A hazard needs a real (nonzero) register match and a producer that is
  // later than the consumer.
  always_comb begin
    dataStall = 1'b0;
    if (dRs != 5'd0) begin
      if (eDest == dRs && eTnew > dTuseRs) dataStall = 1'b1;
      if (mDest == dRs && mTnew > dTuseRs) dataStall = 1'b1;
    end
    if (dRt != 5'd0) begin
      if (eDest == dRt && eTnew > dTuseRt) dataStall = 1'b1;
      if (mDest == dRt && mTnew > dTuseRt) dataStall = 1'b1;
    end
  end

  assign MD_Start     = eCls.mdMult | eCls.mdDiv;
  assign MD_Busy      = (busyCnt_q != '0);
  assign mdStall      = isMdClass(dCls) & (MD_Start | MD_Busy);
  assign Stall        = dataStall | mdStall;
  assign PC_WrEn      = ~Stall;
  assign FD_REG_WrEn  = ~Stall;
  assign DE_REG_Flush = Stall;

  // Busy counter next state: a new start always reloads (last start wins),
  // otherwise count down and park at zero.
  always_comb begin
    busyCnt_d = busyCnt_q;
    if (eCls.mdMult)
      busyCnt_d = CNT_W'(MULT_CYCLES);
    else if (eCls.mdDiv)
      busyCnt_d = CNT_W'(DIV_CYCLES);
    else if (busyCnt_q != '0)
      busyCnt_d = busyCnt_q - 1'b1;
  end

  // Reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busyCnt_q <= '0;
    else       busyCnt_q <= busyCnt_d;
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt_q, stallCnt_d;

  // Count stalled cycles, sticking at all-ones instead of wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (Stall && stallCnt_q != 32'hFFFF_FFFF)
      stallCnt_d = stallCnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stallCnt_q <= '0;
    else       stallCnt_q <= stallCnt_d;
  end

  assign Stall_Cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_md
// Self-checking bench for hazard_ctrl_md: a table of single-cycle hazard
// vectors plus hand-written multi-cycle pipeline sequences. Extra checks for
// the stall counter are compiled when HAZARD_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_md;

  logic        clk;
  logic        reset;
  logic [31:0] D_Instr, E_Instr, M_Instr;
  logic        Stall, PC_WrEn, FD_REG_WrEn, DE_REG_Flush, MD_Busy, MD_Start;
`ifdef HAZARD_PERF_EN
  logic [31:0] Stall_Cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl_md dut (
    .clk          (clk),
    .reset        (reset),
    .D_Instr      (D_Instr),
    .E_Instr      (E_Instr),
    .M_Instr      (M_Instr),
    .Stall        (Stall),
    .PC_WrEn      (PC_WrEn),
    .FD_REG_WrEn  (FD_REG_WrEn),
    .DE_REG_Flush (DE_REG_Flush),
    .MD_Busy      (MD_Busy),
    .MD_Start     (MD_Start)
`ifdef HAZARD_PERF_EN
    ,
    .Stall_Cnt    (Stall_Cnt)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction builders
  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt,
                                        input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] m;
    logic        expStall;
    logic        expStart;
  } vec_t;

  vec_t vecs[26];

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [31:0] e,
                               input logic [31:0] m);
    D_Instr = d;
    E_Instr = e;
    M_Instr = m;
    #1;
  endtask

  task automatic checkBit(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %b expected %b", tag, act, exp);
    end
  endtask

  task automatic checkInt(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expStall,
                             input logic expStart, input logic expBusy);
    checkBit({tag, "/Stall"},        Stall,        expStall);
    checkBit({tag, "/PC_WrEn"},      PC_WrEn,      ~expStall);
    checkBit({tag, "/FD_REG_WrEn"},  FD_REG_WrEn,  ~expStall);
    checkBit({tag, "/DE_REG_Flush"}, DE_REG_Flush, expStall);
    checkBit({tag, "/MD_Start"},     MD_Start,     expStart);
    checkBit({tag, "/MD_Busy"},      MD_Busy,      expBusy);
  endtask

  // Common instruction words
  logic [31:0] lw1, adduD, beqD, adduE0, addu3, addu5, sw5, lw5, lw6, addu4;
  logic [31:0] jr4, sll7, lw4, mult, mfhi6, addu6, beq6, jal, jr31, lw31;
  logic [31:0] lui8, beq08, div, mtlo2, addu9, beq9, sw1, addu211, lw3, sw3;
  logic [31:0] lw43, multD, mflo7, multu;

  // Mult in E / mfhi in D with default latencies: 6 stall cycles, 5 busy.
  task automatic runMultMfhi(input string tag);
    applyStimulus(mfhi6, mult, 32'h0);
    checkOutput({tag, "/c0"}, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      applyStimulus(mfhi6, 32'h0, (k == 1) ? mult : 32'h0);
      checkOutput($sformatf("%s/c%0d", tag, k), 1'b1, 1'b0, 1'b1);
    end
    tick();
    applyStimulus(mfhi6, 32'h0, 32'h0);
    checkOutput({tag, "/c6"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int busyCycles;

    lw1     = itype(6'h23, 2, 1, 0);
    adduD   = rtype(1, 3, 2, 0, 6'h21);
    beqD    = itype(6'h04, 1, 0, 4);
    adduE0  = rtype(1, 2, 0, 0, 6'h21);
    addu3   = rtype(0, 0, 3, 0, 6'h21);
    addu5   = rtype(1, 2, 5, 0, 6'h21);
    sw5     = itype(6'h2b, 6, 5, 0);
    lw5     = itype(6'h23, 2, 5, 0);
    lw6     = itype(6'h23, 2, 6, 0);
    addu4   = rtype(1, 2, 4, 0, 6'h21);
    jr4     = rtype(4, 0, 0, 0, 6'h08);
    sll7    = rtype(0, 4, 7, 2, 6'h00);
    lw4     = itype(6'h23, 2, 4, 0);
    mult    = rtype(4, 5, 0, 0, 6'h18);
    mfhi6   = rtype(0, 0, 6, 0, 6'h10);
    addu6   = rtype(6, 3, 2, 0, 6'h21);
    beq6    = itype(6'h04, 6, 0, 1);
    jal     = {6'h03, 26'h100};
    jr31    = rtype(31, 0, 0, 0, 6'h08);
    lw31    = itype(6'h23, 2, 31, 0);
    lui8    = itype(6'h0f, 0, 8, 16'h1234);
    beq08   = itype(6'h04, 0, 8, 1);
    div     = rtype(8, 9, 0, 0, 6'h1a);
    mtlo2   = rtype(2, 0, 0, 0, 6'h13);
    addu9   = rtype(1, 2, 9, 0, 6'h21);
    beq9    = itype(6'h04, 9, 0, 1);
    sw1     = itype(6'h2b, 2, 1, 0);
    addu211 = rtype(1, 1, 2, 0, 6'h21);
    lw3     = itype(6'h23, 2, 3, 0);
    sw3     = itype(6'h2b, 6, 3, 0);
    lw43    = itype(6'h23, 3, 4, 0);
    multD   = rtype(4, 5, 0, 0, 6'h18);
    mflo7   = rtype(0, 0, 7, 0, 6'h12);
    multu   = rtype(4, 5, 0, 0, 6'h19);

    //          D        E       M      Stall Start
    vecs[0]  = '{32'h0,  32'h0,  32'h0, 1'b0, 1'b0};
    vecs[1]  = '{adduD,  lw1,    32'h0, 1'b1, 1'b0};
    vecs[2]  = '{adduD,  32'h0,  lw1,   1'b0, 1'b0};
    vecs[3]  = '{beqD,   32'h0,  lw1,   1'b1, 1'b0};
    vecs[4]  = '{addu3,  adduE0, 32'h0, 1'b0, 1'b0};
    vecs[5]  = '{sw5,    addu5,  32'h0, 1'b0, 1'b0};
    vecs[6]  = '{sw5,    lw5,    32'h0, 1'b0, 1'b0};
    vecs[7]  = '{sw5,    lw6,    32'h0, 1'b1, 1'b0};
    vecs[8]  = '{jr4,    addu4,  32'h0, 1'b1, 1'b0};
    vecs[9]  = '{sll7,   addu4,  32'h0, 1'b0, 1'b0};
    vecs[10] = '{sll7,   lw4,    32'h0, 1'b1, 1'b0};
    vecs[11] = '{adduD,  mult,   32'h0, 1'b0, 1'b1};
    vecs[12] = '{mfhi6,  mult,   32'h0, 1'b1, 1'b1};
    vecs[13] = '{addu6,  mfhi6,  32'h0, 1'b0, 1'b0};
    vecs[14] = '{beq6,   mfhi6,  32'h0, 1'b1, 1'b0};
    vecs[15] = '{jr31,   jal,    32'h0, 1'b0, 1'b0};
    vecs[16] = '{jr31,   lw31,   32'h0, 1'b1, 1'b0};
    vecs[17] = '{beq08,  lui8,   32'h0, 1'b1, 1'b0};
    vecs[18] = '{mtlo2,  div,    32'h0, 1'b1, 1'b1};
    vecs[19] = '{beq9,   32'h0,  addu9, 1'b0, 1'b0};
    vecs[20] = '{addu211, sw1,   32'h0, 1'b0, 1'b0};
    vecs[21] = '{sw3,    32'h0,  lw3,   1'b0, 1'b0};
    vecs[22] = '{lw43,   32'h0,  lw3,   1'b0, 1'b0};
    vecs[23] = '{multD,  lw4,    32'h0, 1'b1, 1'b0};
    vecs[24] = '{mflo7,  multu,  32'h0, 1'b1, 1'b1};
    vecs[25] = '{mflo7,  32'h0,  32'h0, 1'b0, 1'b0};

    reset = 1'b1;
    applyStimulus(32'h0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("reset", 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_EN
    checkInt("reset/Stall_Cnt", longint'(Stall_Cnt), 0);
`endif

    // Reset is held so the busy counter stays at zero while the purely
    // combinational decode is exercised vector by vector.
    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].d, vecs[i].e, vecs[i].m);
      checkOutput($sformatf("vec%0d", i), vecs[i].expStall, vecs[i].expStart, 1'b0);
      tick();
    end

    reset = 1'b0;
    tick();

    // lw then dependent addu: one stall, then clear once lw is in M.
    applyStimulus(adduD, lw1, 32'h0);
    checkOutput("lwAddu/c0", 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(adduD, 32'h0, lw1);
    checkOutput("lwAddu/c1", 1'b0, 1'b0, 1'b0);

    // lw then dependent beq: stall in E and in M.
    tick();
    applyStimulus(beqD, lw1, 32'h0);
    checkOutput("lwBeq/c0", 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(beqD, 32'h0, lw1);
    checkOutput("lwBeq/c1", 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(beqD, 32'h0, 32'h0);
    checkOutput("lwBeq/c2", 1'b0, 1'b0, 1'b0);

    tick();
    runMultMfhi("multMfhi");

    // div followed by reset on the third busy cycle.
    tick();
    applyStimulus(mflo7, div, 32'h0);
    checkOutput("divRst/c0", 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(mflo7, 32'h0, div);
    checkOutput("divRst/c1", 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(mflo7, 32'h0, 32'h0);
    tick();
    checkOutput("divRst/c3", 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("divRst/inReset", 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("divRst/released", 1'b0, 1'b0, 1'b0);

    // Back-to-back starts: the later mult latency replaces the div latency.
    applyStimulus(32'h0, div, 32'h0);
    tick();
    applyStimulus(32'h0, mult, div);
    tick();
    applyStimulus(32'h0, 32'h0, mult);
    busyCycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!MD_Busy) break;
      busyCycles++;
      tick();
    end
    checkInt("lastStartWins/busyCycles", busyCycles, 5);
    checkOutput("lastStartWins/idle", 1'b0, 1'b0, 1'b0);

`ifdef HAZARD_PERF_EN
    reset = 1'b1;
    applyStimulus(32'h0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    checkInt("perf/cleared", longint'(Stall_Cnt), 0);
    runMultMfhi("perfMult");
    checkInt("perf/count6", longint'(Stall_Cnt), 6);

    applyStimulus(beqD, lw1, 32'h0);
    force dut.stallCnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stallCnt_q;
    #1;
    checkBit("perf/stallForSat", Stall, 1'b1);
    tick();
    checkInt("perf/saturated", longint'(Stall_Cnt), longint'(32'hFFFF_FFFF));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
